// File: rtl/counter_run_scheduler_if.sv
// Requester-facing bundle of the shared counter scheduler: per-requester run
// parameters in, shared counter value and ownership/completion status out.
interface counter_run_scheduler_if #(
    parameter int WIDTH = 6
);
    logic [1:0]       req;
    logic [1:0]       dir;
    logic [WIDTH-1:0] start0;
    logic [WIDTH-1:0] start1;
    logic [WIDTH-1:0] limit0;
    logic [WIDTH-1:0] limit1;
    logic             enable;
    logic [WIDTH-1:0] q;
    logic [1:0]       grant;
    logic             busy;
    logic [1:0]       done;

    modport master (
        output req, dir, start0, start1, limit0, limit1, enable,
        input  q, grant, busy, done
    );

    modport slave (
        input  req, dir, start0, start1, limit0, limit1, enable,
        output q, grant, busy, done
    );
endinterface

// File: rtl/counter_run_scheduler.sv
// Lends one shared WIDTH-bit up/down counter to two requesters in round-robin
// order: grant, load start, step on enable until the limit, pulse done.
module counter_run_scheduler #(
    parameter int WIDTH = 6
) (
    input logic                    clk,
    input logic                    clear,
    counter_run_scheduler_if.slave bus
);
    // state | meaning
    // IDLE  | no owner; arbitrate pending requests, q holds
    // LOAD  | owner granted; q takes the latched start value
    // RUN   | step q once per enable tick until it equals the latched limit
    // DONE  | one-cycle done pulse on the owner's bit, then release
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nx;
    logic [WIDTH-1:0] q, q_nx;
    logic [1:0]       grant, grant_nx;
    logic             owner, owner_nx;
    logic             last, last_nx;
    logic             dir_l, dir_nx;
    logic [WIDTH-1:0] start_l, start_nx;
    logic [WIDTH-1:0] limit_l, limit_nx;

    logic             win1;
    logic             owner_req;
    logic             at_limit;
    logic [WIDTH-1:0] q_step;

    // Requester 1 wins when it is alone, or when both ask and 0 went last.
    assign win1      = bus.req[1] & (~bus.req[0] | ~last);
    assign owner_req = bus.req[owner];
    assign at_limit  = (q == limit_l);
    assign q_step    = dir_l ? (q - ONE) : (q + ONE);

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            q       <= '0;
            grant   <= 2'b00;
            owner   <= 1'b0;
            last    <= 1'b1;
            dir_l   <= 1'b0;
            start_l <= '0;
            limit_l <= '0;
        end else begin
            state   <= state_nx;
            q       <= q_nx;
            grant   <= grant_nx;
            owner   <= owner_nx;
            last    <= last_nx;
            dir_l   <= dir_nx;
            start_l <= start_nx;
            limit_l <= limit_nx;
        end
    end

    always_comb begin
        state_nx = state;
        q_nx     = q;
        grant_nx = grant;
        owner_nx = owner;
        last_nx  = last;
        dir_nx   = dir_l;
        start_nx = start_l;
        limit_nx = limit_l;

        case (state)
            IDLE: begin
                if (|bus.req) begin
                    owner_nx = win1;
                    grant_nx = win1 ? 2'b10 : 2'b01;
                    dir_nx   = win1 ? bus.dir[1] : bus.dir[0];
                    start_nx = win1 ? bus.start1 : bus.start0;
                    limit_nx = win1 ? bus.limit1 : bus.limit0;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                // The start value is loaded even when the owner walks away here.
                q_nx = start_l;
                if (!owner_req) begin
                    grant_nx = 2'b00;
                    state_nx = IDLE;
                end else begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    grant_nx = 2'b00;
                    state_nx = IDLE;
                end else if (at_limit) begin
                    state_nx = DONE;
                end else if (bus.enable) begin
                    q_nx = q_step;
                end
            end
            DONE: begin
                last_nx  = owner;
                grant_nx = 2'b00;
                state_nx = IDLE;
            end
            default: begin
                grant_nx = 2'b00;
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.q     = q;
    assign bus.grant = grant;
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE) ? grant : 2'b00;
endmodule

// File: tb/tb_counter_run_scheduler.sv
// Randomized self-checking bench for counter_run_scheduler against a
// run-level model: step counts, wrap arithmetic and round-robin ownership.
module tb_counter_run_scheduler;
    localparam int W = 6;

    logic clk;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    int   model_last = 1;

    counter_run_scheduler_if #(.WIDTH(W)) bus ();

    counter_run_scheduler #(.WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_run(input string name, input logic [1:0] mask, input logic [1:0] d2,
                          input logic [W-1:0] s0, input logic [W-1:0] s1,
                          input logic [W-1:0] l0, input logic [W-1:0] l1,
                          input int mode, input bit keep);
        int             w;
        logic [1:0]     g_exp;
        logic           d;
        logic [W-1:0]   s, l, sdiff, q_exp, kk;
        int             nsteps, steps, cyc, dis, wc, rc;
        bit             en, got_done;

        w      = (mask == 2'b11) ? (1 - model_last) : (mask[1] ? 1 : 0);
        g_exp  = (w == 1) ? 2'b10 : 2'b01;
        d      = d2[w];
        s      = (w == 1) ? s1 : s0;
        l      = (w == 1) ? l1 : l0;
        sdiff  = d ? (s - l) : (l - s);
        nsteps = int'(sdiff);

        bus.req    = mask;
        bus.dir    = d2;
        bus.start0 = s0;
        bus.start1 = s1;
        bus.limit0 = l0;
        bus.limit1 = l1;
        bus.enable = 1'b1;

        wc = 0;
        do begin
            @(negedge clk);
            wc++;
        end while (bus.grant == 2'b00 && wc < 8);
        checks++;
        if (bus.grant !== g_exp) begin
            errors++;
            $display("FAIL %s grant got %b want %b", name, bus.grant, g_exp);
        end
        checks++;
        if (wc != 1 || bus.busy !== 1'b1 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL %s grant_latency got %0d busy %b done %b want 1 1 00", name, wc, bus.busy, bus.done);
        end

        // Scramble every run parameter: the granted run must ignore them.
        bus.dir    = 2'($urandom);
        bus.start0 = W'($urandom);
        bus.start1 = W'($urandom);
        bus.limit0 = W'($urandom);
        bus.limit1 = W'($urandom);
        bus.enable = 1'($urandom);
        @(negedge clk);
        checks++;
        if (bus.q !== s || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL %s load q got %0d done %b want %0d 00", name, bus.q, bus.done, s);
        end

        steps = 0; cyc = 1; dis = 0; rc = 0; got_done = 0;
        while (!got_done && cyc < 300) begin
            case (mode)
                0:       en = 1'b1;
                1:       en = (rc % 2) == 1;
                default: en = 1'($urandom);
            endcase
            rc++;
            bus.enable = en;
            @(negedge clk);
            cyc++;
            if (steps == nsteps) begin
                got_done = 1;
                checks++;
                if (bus.done !== g_exp || bus.q !== l || bus.grant !== g_exp) begin
                    errors++;
                    $display("FAIL %s done got %b q %0d want %b q %0d", name, bus.done, bus.q, g_exp, l);
                end
            end else begin
                if (en) steps++;
                else    dis++;
                kk    = W'(steps);
                q_exp = d ? (s - kk) : (s + kk);
                checks++;
                if (bus.q !== q_exp || bus.done !== 2'b00 || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s step q got %0d done %b want %0d 00", name, bus.q, bus.done, q_exp);
                end
            end
        end
        checks++;
        if (!got_done || cyc != 2 + nsteps + dis) begin
            errors++;
            $display("FAIL %s done_latency got %0d want %0d", name, cyc, 2 + nsteps + dis);
        end

        if (!keep) bus.req = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 2'b00 || bus.q !== l) begin
            errors++;
            $display("FAIL %s release grant %b busy %b done %b q %0d want 00 0 00 %0d",
                     name, bus.grant, bus.busy, bus.done, bus.q, l);
        end
        model_last = w;
    endtask

    task automatic pulse_clear();
        bus.req = 2'b00;
        clear   = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        model_last = 1;
    endtask

    task automatic wait_q(input string name, input logic [W-1:0] target);
        int n;
        n = 0;
        while (bus.q !== target && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (bus.q !== target) begin
            checks++;
            errors++;
            $display("FAIL %s wait_q got %0d want %0d", name, bus.q, target);
        end
    endtask

    task automatic test_reset();
        clear      = 1'b1;
        bus.req    = 2'b11;
        bus.dir    = 2'b00;
        bus.start0 = 6'd5;
        bus.start1 = 6'd6;
        bus.limit0 = 6'd7;
        bus.limit1 = 6'd8;
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.q !== '0 || bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL reset q %0d grant %b busy %b done %b want 0 00 0 00",
                     bus.q, bus.grant, bus.busy, bus.done);
        end
        clear      = 1'b0;
        bus.req    = 2'b00;
        model_last = 1;
        @(negedge clk);
    endtask

    task automatic test_up_run();
        pulse_clear();
        do_run("up", 2'b01, 2'b00, 6'd3, 6'd0, 6'd7, 6'd0, 0, 0);
    endtask

    task automatic test_down_wrap();
        do_run("down_wrap", 2'b10, 2'b10, 6'd0, 6'd1, 6'd0, 6'd62, 0, 0);
    endtask

    task automatic test_arbitration();
        pulse_clear();
        do_run("arb_a", 2'b11, 2'b00, 6'd2, 6'd10, 6'd5, 6'd12, 0, 1);
        do_run("arb_b", 2'b11, 2'b01, 6'd20, 6'd30, 6'd18, 6'd33, 0, 1);
        do_run("arb_c", 2'b11, 2'b10, 6'd40, 6'd1, 6'd41, 6'd63, 0, 0);
    endtask

    task automatic test_zero_and_gating();
        do_run("zero", 2'b01, 2'b00, 6'd9, 6'd0, 6'd9, 6'd0, 0, 0);
        do_run("gate", 2'b01, 2'b00, 6'd0, 6'd0, 6'd2, 6'd0, 1, 0);
    endtask

    task automatic test_abort();
        pulse_clear();
        bus.req    = 2'b01;
        bus.dir    = 2'b00;
        bus.start0 = 6'd0;
        bus.limit0 = 6'd30;
        bus.enable = 1'b1;
        wait_q("abort", 6'd5);
        bus.req = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 2'b00 || bus.q !== 6'd5) begin
            errors++;
            $display("FAIL abort grant %b busy %b done %b q %0d want 00 0 00 5",
                     bus.grant, bus.busy, bus.done, bus.q);
        end
        bus.req    = 2'b11;
        bus.start0 = 6'd12;
        @(negedge clk);
        checks++;
        if (bus.grant !== 2'b01 || bus.q !== 6'd5) begin
            errors++;
            $display("FAIL abort_priority grant %b q %0d want 01 5", bus.grant, bus.q);
        end
        bus.req = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.q !== 6'd12 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL load_abort grant %b busy %b q %0d done %b want 00 0 12 00",
                     bus.grant, bus.busy, bus.q, bus.done);
        end
    endtask

    task automatic test_clear_midrun();
        pulse_clear();
        do_run("pre_clear", 2'b01, 2'b00, 6'd4, 6'd0, 6'd6, 6'd0, 0, 0);
        bus.req    = 2'b10;
        bus.dir    = 2'b00;
        bus.start1 = 6'd0;
        bus.limit1 = 6'd40;
        bus.enable = 1'b1;
        wait_q("clear_mid", 6'd20);
        clear = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.q !== '0 || bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL clear_mid q %0d grant %b busy %b done %b want 0 00 0 00",
                     bus.q, bus.grant, bus.busy, bus.done);
        end
        clear   = 1'b0;
        bus.req = 2'b11;
        @(negedge clk);
        checks++;
        if (bus.grant !== 2'b01) begin
            errors++;
            $display("FAIL clear_rr grant got %b want 01", bus.grant);
        end
        pulse_clear();
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_run("random", 2'($urandom_range(1, 3)), 2'($urandom),
                   W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    initial begin
        clear      = 1'b0;
        bus.req    = 2'b00;
        bus.dir    = 2'b00;
        bus.start0 = '0;
        bus.start1 = '0;
        bus.limit0 = '0;
        bus.limit1 = '0;
        bus.enable = 1'b0;
        test_reset();
        test_up_run();
        test_down_wrap();
        test_arbitration();
        test_zero_and_gating();
        test_abort();
        test_clear_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_run_scheduler.md
# counter_run_scheduler

Shares one WIDTH-bit synchronous counting resource between two requesters. Each requester supplies a direction, a start value and a limit value. A round-robin arbiter grants the resource, and an FSM loads the start value. The counter then steps once per `enable` tick until it reaches the limit, and the block signals completion. The block sits above the team's counter datapath: it sequences load, count and stop, and owns the shared counter register.

## Interface
- `WIDTH`, default 6: counter and value width in bits.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `clear`, in, 1: reset, synchronous, active-high.
- `req`, in, 2: per-requester request; must be held high for the whole run.
- `dir`, in, 2: per-requester direction; 0 = up, 1 = down (reverse).
- `start0`, `start1`, in, WIDTH: start values for requester 0 and 1.
- `limit0`, `limit1`, in, WIDTH: terminal values for requester 0 and 1.
- `enable`, in, 1: count tick; the counter steps only in cycles where it is high.
- `q`, out, WIDTH: shared counter value.
- `grant`, out, 2: one-hot owner of the counter; 00 when idle.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 2: one-cycle completion pulse, on the bit of the owning requester.

## Operation
- Reset values: state IDLE, `q`=0, `grant`=00, `busy`=0, `done`=00, round-robin pointer `last`=1 (requester 0 wins first).
- The FSM has four states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any `req` bit is high: grant one requester, latch its `dir`/start/limit into internal registers, set `grant`, go to LOAD.
  - Arbitration: with a single requester, it wins. With both, the requester that is not `last` wins.
  - `q` holds its value while in IDLE.
- LOAD: `q` ← latched start; go to RUN.
- RUN, evaluated in this priority order:
  1. `req[owner]`=0 → abort: go to IDLE, clear `grant`, no `done`, `q` holds, `last` unchanged.
  2. `q` == latched limit → go to DONE. This does not require `enable`.
  3. `enable`=1 → `q` ← `q`+1 when dir=0, or `q`−1 when dir=1, modulo 2^WIDTH (wrap 63→0 up, 0→63 down for WIDTH=6).
  4. Otherwise hold.
- DONE:
  - `done` = `grant` for exactly this one cycle.
  - At the next edge: `last` ← owner, `grant` ← 00, go to IDLE.
  - `q` holds the limit value.
- Abort in LOAD: a dropped `req[owner]` in LOAD also aborts to IDLE. In that case `q` is still loaded with the start value on that edge.
- Latched values are frozen for the whole run. Changes to `start*`/`limit*`/`dir` after grant are ignored.
- A request from the non-owner during a run waits; it is arbitrated in the next IDLE cycle.
- Step count is (limit−start) mod 2^WIDTH for up, (start−limit) mod 2^WIDTH for down. When start==limit the run takes zero steps.

## Timing
- Let E0 be the IDLE edge that samples `req`:
  - `grant`/`busy` rise after E0.
  - `q`=start after E1.
  - With `enable` held at 1, the S steps occur on E2..E(1+S).
  - DONE is entered on E(2+S), so `done` is high during the cycle after E(2+S). That is S+2 cycles after `grant` rises.
  - `grant`, `busy` and `done` fall after E(3+S).
- At least one IDLE cycle separates consecutive runs. The earliest next grant edge is E(4+S).
- Each cycle with `enable`=0 during RUN (before the limit is reached) adds one cycle of latency.
- Synchronous `clear` takes priority over all other inputs in any state, including mid-run. All outputs take their reset values after the edge; no `done` is produced.

## Test plan
- Up run: `clear` pulse, then `req`=01, `dir[0]`=0, start0=3, limit0=7, `enable`=1 → `q` goes 3,4,5,6,7; `done`=01 exactly 6 cycles after `grant`=01 rises; then `grant`=00, `busy`=0, `q`=7.
- Down wrap: `req`=10, `dir[1]`=1, start1=1, limit1=62 → `q` goes 1,0,63,62; `done`=10 five cycles after `grant`=10; then `grant` returns to 00.
- Arbitration: after reset, `req`=11 held → first `grant`=01 and `done`=01. The next grant is 10 (round-robin), then 01 again.
- Enable gating and zero steps: start0=limit0=9 → `done` two cycles after `grant`. Then start0=0, limit0=2 with `enable` high only every other cycle → `q` changes only on enabled edges; `done` arrives after 2 enabled steps.
- Abort: drop `req[0]` while `q`=5 in RUN → `grant`=00 and `busy`=0 after the next edge, `done` stays 00, `q` holds 5, and requester 0 keeps priority over requester 1.
- `clear` mid-run at `q`=20 → after the edge, `q`=0, `grant`=00, `busy`=0, `done`=00; with `req`=11, the next grant goes to requester 0.
